// File: rtl/glyph_renderer.sv
// glyph_renderer: renders NUM_GLYPHS cell-grid bitmap glyphs onto the VGA raster as 24-bit RGB.
// Ports: clk9MHz/rst_n (async active-low) clock and reset; start enables output (else black);
// vgaCount/lineCount raster position; glyphPixels/fgColor/bgColor/blinkEn load data offered with
// loadValid and taken while loadReady; redPixels/greenPixels/bluePixels pixel colour two clocks
// after the raster position; frameDone pulses with the last pixel of the glyph area.
module glyph_renderer #(
  parameter int NUM_GLYPHS   = 4,
  parameter int GRID_W       = 5,
  parameter int GRID_H       = 5,
  parameter int CELL_W       = 50,
  parameter int CELL_H       = 50,
  parameter int X_ORIGIN     = 44,
  parameter int Y_ORIGIN     = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                 clk9MHz,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [9:0]                           vgaCount,
  input  logic [8:0]                           lineCount,
  input  logic [NUM_GLYPHS*GRID_W*GRID_H-1:0]  glyphPixels,
  input  logic [23:0]                          fgColor,
  input  logic [23:0]                          bgColor,
  input  logic                                 blinkEn,
  input  logic                                 loadValid,
  output logic                                 loadReady,
  output logic [7:0]                           redPixels,
  output logic [7:0]                           greenPixels,
  output logic [7:0]                           bluePixels,
  output logic                                 frameDone
);
  localparam int TOT = NUM_GLYPHS*GRID_W*GRID_H;
  localparam int IW  = $clog2(TOT);
  localparam int XSW = $clog2(CELL_W+1);
  localparam int YSW = $clog2(CELL_H+1);
  localparam int CLW = $clog2(GRID_W+1);
  localparam int GLW = $clog2(NUM_GLYPHS+1);
  localparam int RWW = $clog2(GRID_H+1);
  localparam int BFW = $clog2(BLINK_FRAMES+1);

  logic [TOT-1:0] pend_bits, act_bits, eff_bits;
  logic [23:0]    pend_fg, pend_bg, act_fg, act_bg, eff_fg, eff_bg, s1_fg, s1_bg;
  logic           pend_blink, act_blink, eff_blink, full;
  logic [8:0]     line_q;
  logic [XSW-1:0] xsub, cx_sub, nx_sub;
  logic [CLW-1:0] xcol, cx_col, nx_col;
  logic [GLW-1:0] xgl, cx_gl, nx_gl;
  logic [YSW-1:0] ysub, cy_sub;
  logic [RWW-1:0] ycell, cy_cell;
  logic [BFW-1:0] bcnt;
  logic           phase, eff_phase, fs, commit, accept, hin, vin, xs_wrap, col_wrap, y_step, last;
  logic [IW-1:0]  idx;
  logic           s1_on, s1_bit, s1_last;

  assign loadReady = !full;

  // The cx_*/cy_* values are the tracking state as seen by the pixel currently on the inputs:
  // origin crossings and line changes are folded in combinationally so that counter values at
  // cycle n land in RGB at exactly n+2. Likewise eff_* let a commit cover its own frameStart pixel.
  always_comb begin
    fs        = vgaCount == '0 && lineCount == '0;
    commit    = fs && full;
    accept    = loadValid && !full;
    eff_bits  = commit ? pend_bits : act_bits;
    eff_fg    = commit ? pend_fg : act_fg;
    eff_bg    = commit ? pend_bg : act_bg;
    eff_blink = commit ? pend_blink : act_blink;
    eff_phase = fs && bcnt == BFW'(BLINK_FRAMES-1) ? !phase : phase;
    cx_sub    = vgaCount == 10'(X_ORIGIN) ? '0 : xsub;
    cx_col    = vgaCount == 10'(X_ORIGIN) ? '0 : xcol;
    cx_gl     = vgaCount == 10'(X_ORIGIN) ? '0 : xgl;
    hin       = cx_gl < GLW'(NUM_GLYPHS);
    xs_wrap   = cx_sub == XSW'(CELL_W-1);
    col_wrap  = cx_col == CLW'(GRID_W-1);
    nx_sub    = !hin ? cx_sub : xs_wrap ? '0 : cx_sub + 1'b1;
    nx_col    = !(hin && xs_wrap) ? cx_col : col_wrap ? '0 : cx_col + 1'b1;
    nx_gl     = hin && xs_wrap && col_wrap ? cx_gl + 1'b1 : cx_gl;
    // Counters stop once past the glyph area so the region stays outside until the next origin.
    y_step    = lineCount != line_q && ycell < RWW'(GRID_H);
    cy_sub    = lineCount == 9'(Y_ORIGIN) ? '0 : !y_step ? ysub :
                ysub == YSW'(CELL_H-1) ? '0 : ysub + 1'b1;
    cy_cell   = lineCount == 9'(Y_ORIGIN) ? '0 :
                y_step && ysub == YSW'(CELL_H-1) ? ycell + 1'b1 : ycell;
    vin       = cy_cell < RWW'(GRID_H);
    last      = hin && vin && cx_gl == GLW'(NUM_GLYPHS-1) && col_wrap && xs_wrap &&
                cy_cell == RWW'(GRID_H-1) && cy_sub == YSW'(CELL_H-1);
    // Bitmap is MSB-first: glyph 0 top-left cell is the top bit.
    idx       = IW'(TOT - 1 - (int'(cx_gl)*GRID_W*GRID_H + int'(cy_cell)*GRID_W + int'(cx_col)));
  end

  always_ff @(posedge clk9MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_bits  <= '0;
      pend_fg    <= '0;
      pend_bg    <= '0;
      pend_blink <= 1'b0;
      full       <= 1'b0;
      act_bits   <= '0;
      act_fg     <= 24'hFFFFFF;
      act_bg     <= '0;
      act_blink  <= 1'b0;
      line_q     <= '0;
      xsub       <= '0;
      xcol       <= '0;
      xgl        <= '0;
      ysub       <= '0;
      ycell      <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      s1_on      <= 1'b0;
      s1_bit     <= 1'b0;
      s1_fg      <= '0;
      s1_bg      <= '0;
      s1_last    <= 1'b0;
      {redPixels, greenPixels, bluePixels} <= '0;
      frameDone  <= 1'b0;
    end else begin
      if (accept) begin
        pend_bits  <= glyphPixels;
        pend_fg    <= fgColor;
        pend_bg    <= bgColor;
        pend_blink <= blinkEn;
      end
      full       <= accept ? 1'b1 : commit ? 1'b0 : full;
      act_bits   <= eff_bits;
      act_fg     <= eff_fg;
      act_bg     <= eff_bg;
      act_blink  <= eff_blink;
      line_q     <= lineCount;
      xsub       <= nx_sub;
      xcol       <= nx_col;
      xgl        <= nx_gl;
      ysub       <= cy_sub;
      ycell      <= cy_cell;
      bcnt       <= !fs ? bcnt : bcnt == BFW'(BLINK_FRAMES-1) ? '0 : bcnt + 1'b1;
      phase      <= eff_phase;
      s1_on      <= start && hin && vin;
      s1_bit     <= hin && vin && eff_bits[idx];
      s1_fg      <= eff_blink && eff_phase ? eff_bg : eff_fg;
      s1_bg      <= eff_bg;
      s1_last    <= last;
      {redPixels, greenPixels, bluePixels} <= !s1_on ? '0 : s1_bit ? s1_fg : s1_bg;
      frameDone  <= s1_last;
    end
  end
endmodule

// File: tb/tb_glyph_renderer.sv
// tb_glyph_renderer: directed bench for glyph_renderer on a small 48x13 raster.
module tb_glyph_renderer;
  logic         clk9MHz = 1'b0;
  logic         rst_n, start, blinkEn, loadValid, loadReady, frameDone;
  logic [9:0]   vgaCount;
  logic [8:0]   lineCount;
  logic [99:0]  glyphPixels;
  logic [23:0]  fgColor, bgColor;
  logic [7:0]   redPixels, greenPixels, bluePixels;
  logic [23:0]  ep;
  logic         edp;
  int           ppx, ppy;
  int           checks = 0;
  int           failures = 0;
  logic [99:0]  zb, ga, gb, gc, ge;

  glyph_renderer #(
    .NUM_GLYPHS(4), .GRID_W(5), .GRID_H(5), .CELL_W(2), .CELL_H(2),
    .X_ORIGIN(3), .Y_ORIGIN(1), .BLINK_FRAMES(2)
  ) dut (
    .clk9MHz(clk9MHz), .rst_n(rst_n), .start(start), .vgaCount(vgaCount),
    .lineCount(lineCount), .glyphPixels(glyphPixels), .fgColor(fgColor),
    .bgColor(bgColor), .blinkEn(blinkEn), .loadValid(loadValid), .loadReady(loadReady),
    .redPixels(redPixels), .greenPixels(greenPixels), .bluePixels(bluePixels),
    .frameDone(frameDone)
  );

  always #5 clk9MHz = ~clk9MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Region: x 3..42 (4 glyphs x 5 cols x 2 px), lines 1..10 (5 rows x 2 lines).
  function automatic logic [23:0] px(input int x, input int y, input logic [99:0] b,
                                     input logic [23:0] fg, input logic [23:0] bg);
    int gx, k;
    if (x < 3 || x > 42 || y < 1 || y > 10) return 24'h0;
    gx = x - 3;
    k = 99 - ((gx / 10) * 25 + ((y - 1) / 2) * 5 + (gx % 10) / 2);
    return b[7'(k)] ? fg : bg;
  endfunction

  // Outputs seen after this edge belong to the raster position driven in the previous call.
  task automatic tick(input int x, input int y, input logic [23:0] e, input logic ed);
    vgaCount = 10'(x);
    lineCount = 9'(y);
    @(posedge clk9MHz);
    #1;
    chk($sformatf("rgb@%0d,%0d", ppx, ppy), 32'({redPixels, greenPixels, bluePixels}), 32'(ep));
    chk($sformatf("done@%0d,%0d", ppx, ppy), 32'(frameDone), 32'(edp));
    ep = e;
    edp = ed;
    ppx = x;
    ppy = y;
  endtask

  task automatic frame(input logic [99:0] b, input logic [23:0] fg, input logic [23:0] bg,
                       input logic on, input int n_pix, input int ld_at);
    for (int p = 0; p < n_pix; p++) begin
      loadValid = (p == ld_at);
      tick(p % 48, p / 48, on ? px(p % 48, p / 48, b, fg, bg) : 24'h0, p % 48 == 42 && p / 48 == 10);
      loadValid = 1'b0;
    end
  endtask

  task automatic load(input logic [99:0] b, input logic [23:0] fg, input logic [23:0] bg,
                      input logic bl);
    glyphPixels = b;
    fgColor = fg;
    bgColor = bg;
    blinkEn = bl;
    loadValid = 1'b1;
    tick(47, 12, 24'h0, 1'b0);
    loadValid = 1'b0;
  endtask

  initial begin
    zb = '0;
    ga = {25'h1FFFFFF, 75'h0};
    gb = {25'h0, 25'h1FFFFFF, 50'h0};
    gc = {75'h0, 25'h1555555};
    ge = '1;
    rst_n = 1'b0; start = 1'b0; loadValid = 1'b0; blinkEn = 1'b0;
    vgaCount = 10'd47; lineCount = 9'd12; glyphPixels = '0; fgColor = '0; bgColor = '0;
    ep = '0; edp = 1'b0; ppx = 47; ppy = 12;
    #3;
    chk("rst_rgb", 32'({redPixels, greenPixels, bluePixels}), 32'h0);
    chk("rst_done", 32'(frameDone), 32'h0);
    chk("rst_ready", 32'(loadReady), 32'h1);
    tick(47, 12, 24'h0, 1'b0);
    tick(47, 12, 24'h0, 1'b0);
    rst_n = 1'b1;
    tick(47, 12, 24'h0, 1'b0);
    start = 1'b1;
    frame(zb, 24'hFFFFFF, 24'h0, 1'b1, 624, -1);
    chk("ready_idle", 32'(loadReady), 32'h1);
    load(ga, 24'hFF0000, 24'h0000FF, 1'b0);
    chk("ready_full", 32'(loadReady), 32'h0);
    load(gb, 24'h00FF00, 24'h000000, 1'b0);
    chk("ready_still_full", 32'(loadReady), 32'h0);
    frame(ga, 24'hFF0000, 24'h0000FF, 1'b1, 624, -1);
    chk("ready_after_commit", 32'(loadReady), 32'h1);
    glyphPixels = gc; fgColor = 24'h00FF00; bgColor = 24'h101010; blinkEn = 1'b0;
    frame(ga, 24'hFF0000, 24'h0000FF, 1'b1, 624, 0);
    chk("ready_coincident", 32'(loadReady), 32'h0);
    frame(gc, 24'h00FF00, 24'h101010, 1'b1, 624, -1);
    chk("ready_after_coincident", 32'(loadReady), 32'h1);
    load(gc, 24'hFFFF00, 24'h000080, 1'b1);
    frame(gc, 24'hFFFF00, 24'h000080, 1'b1, 624, -1);
    frame(gc, 24'h000080, 24'h000080, 1'b1, 624, -1);
    frame(gc, 24'h000080, 24'h000080, 1'b1, 624, -1);
    frame(gc, 24'hFFFF00, 24'h000080, 1'b1, 624, -1);
    frame(gc, 24'hFFFF00, 24'h000080, 1'b1, 624, -1);
    start = 1'b0;
    frame(gc, 24'hFFFF00, 24'h000080, 1'b0, 624, -1);
    start = 1'b1;
    glyphPixels = ge; fgColor = 24'h123456; bgColor = 24'h654321; blinkEn = 1'b0;
    frame(gc, 24'h000080, 24'h000080, 1'b1, 261, 240);
    chk("ready_mid", 32'(loadReady), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", 32'({redPixels, greenPixels, bluePixels}), 32'h0);
    chk("arst_ready", 32'(loadReady), 32'h1);
    chk("arst_done", 32'(frameDone), 32'h0);
    ep = '0; edp = 1'b0; ppx = 47; ppy = 12;
    tick(47, 12, 24'h0, 1'b0);
    tick(47, 12, 24'h0, 1'b0);
    rst_n = 1'b1;
    tick(47, 12, 24'h0, 1'b0);
    frame(zb, 24'hFFFFFF, 24'h0, 1'b1, 624, -1);
    frame(zb, 24'hFFFFFF, 24'h0, 1'b1, 624, -1);
    chk("ready_end", 32'(loadReady), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
